// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone initiator: cmd valid/ready -> stb/stall/ack bus cycle -> rsp valid/ready; best case 3 cycles cmd to rsp.
// Optional ack timeout under `WB_INIT_TIMEOUT_EN` (error response after TIMEOUT waiting cycles); otherwise waits for ack forever.
module wb_initiator #(
  parameter int A_WIDTH = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [A_WIDTH:0]   cmd_addr,
  input  logic [3:0]         cmd_we,
  input  logic [31:0]        cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic               wb_stb_o,
  output logic [A_WIDTH:0]   wb_addr_o,
  output logic [3:0]         wb_we_o,
  output logic [31:0]        wb_data_o,
  input  logic               wb_ack_i,
  input  logic               wb_stall_i,
  input  logic [31:0]        wb_data_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, RESP} state_t;

  state_t state;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : gBadTimeout
    $error("wb_initiator: TIMEOUT must be in 2..255");
  end

  assign cmd_ready = (state == IDLE);

`ifdef WB_INIT_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] toCnt;
  logic       errQ;
  assign rsp_err = errQ;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wb_stb_o  <= 1'b0;
      wb_addr_o <= '0;
      wb_we_o   <= '0;
      wb_data_o <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef WB_INIT_TIMEOUT_EN
      toCnt     <= '0;
      errQ      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wb_stb_o  <= 1'b1;
            wb_addr_o <= cmd_addr;
            wb_we_o   <= cmd_we;
            wb_data_o <= cmd_data;
            state     <= REQ;
          end
        end
        REQ: begin
          // Address/data stay parked after the strobe drops so the bus sees no glitching.
          if (!wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= WAIT_ACK;
`ifdef WB_INIT_TIMEOUT_EN
            toCnt    <= '0;
`endif
          end
        end
        WAIT_ACK: begin
          if (wb_ack_i) begin
            rsp_data  <= wb_data_i;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef WB_INIT_TIMEOUT_EN
            errQ      <= 1'b0;
          end else if (toCnt == TO_LAST) begin
            rsp_data  <= '0;
            errQ      <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            toCnt     <= toCnt + 8'd1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: directed vector table, hand-written corner sequences, then random traffic vs a memory model.
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [8:0]  cmd_addr;
  logic [3:0]  cmd_we;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wb_stb_o;
  logic [8:0]  wb_addr_o;
  logic [3:0]  wb_we_o;
  logic [31:0] wb_data_o;
  logic        wb_ack_i, wb_stall_i;
  logic [31:0] wb_data_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] slaveMem [0:511];
  logic [31:0] refMem   [0:511];

  wb_initiator #(.A_WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_we(cmd_we), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wb_stb_o(wb_stb_o), .wb_addr_o(wb_addr_o), .wb_we_o(wb_we_o), .wb_data_o(wb_data_o),
    .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i), .wb_data_i(wb_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  addr;
    logic [3:0]  we;
    logic [31:0] data;
    int          nStall;
    int          ackDly;
    int          rspWait;
    logic [31:0] expRsp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word memory with byte-enable merge; every transaction returns the pre-write word.
  function automatic logic [31:0] modelTxn(input logic [8:0] a, input logic [3:0] we, input logic [31:0] d);
    logic [31:0] old;
    old = refMem[a];
    for (int b = 0; b < 4; b++)
      if (we[b]) refMem[a][8*b +: 8] = d[8*b +: 8];
    return old;
  endfunction

  // Drives one command, plays the slave (stall count, ack delay, memory), and checks bus and response.
  task automatic doTxn(input logic [8:0] a, input logic [3:0] we, input logic [31:0] d,
                       input int nStall, input int ackDly, input int rspWait, input logic [31:0] expRsp);
    logic [8:0]  capA;
    logic [3:0]  capWe;
    logic [31:0] capD;
    logic [31:0] mask;
    capA = '0; capWe = '0; capD = '0;
    chk1("idle_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_we = we; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = 9'($urandom); cmd_we = 4'($urandom); cmd_data = $urandom;
    for (int i = 0; i <= nStall; i++) begin
      chk1("req_stb", wb_stb_o, 1'b1);
      chk("req_addr", 32'(wb_addr_o), 32'(a));
      chk("req_we", 32'(wb_we_o), 32'(we));
      chk("req_data", wb_data_o, d);
      chk1("req_cmd_ready", cmd_ready, 1'b0);
      capA = wb_addr_o; capWe = wb_we_o; capD = wb_data_o;
      wb_stall_i = (i < nStall);
      wb_ack_i = 1'b1;
      @(posedge clk); #1;
    end
    wb_stall_i = 1'b0;
    for (int j = 0; j <= ackDly; j++) begin
      chk1("wait_stb", wb_stb_o, 1'b0);
      chk1("wait_no_rsp", rsp_valid, 1'b0);
      chk("wait_addr_hold", 32'(wb_addr_o), 32'(a));
      wb_ack_i  = (j == ackDly);
      wb_data_i = (j == ackDly) ? slaveMem[capA] : $urandom;
      @(posedge clk); #1;
    end
    wb_ack_i = 1'b0; wb_data_i = $urandom;
    mask = {{8{capWe[3]}}, {8{capWe[2]}}, {8{capWe[1]}}, {8{capWe[0]}}};
    slaveMem[capA] = (slaveMem[capA] & ~mask) | (capD & mask);
    for (int k = 0; k <= rspWait; k++) begin
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_data", rsp_data, expRsp);
      chk1("rsp_err", rsp_err, 1'b0);
      chk1("rsp_cmd_ready", cmd_ready, 1'b0);
      chk1("rsp_stb", wb_stb_o, 1'b0);
      rsp_ready = (k == rspWait);
      wb_ack_i  = (k != rspWait);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0; wb_ack_i = 1'b0;
    chk1("done_rsp_valid", rsp_valid, 1'b0);
    chk1("done_cmd_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int n;
    logic [8:0]  ra;
    logic [3:0]  rw;
    logic [31:0] rd;
    logic [31:0] ex;

    for (int i = 0; i < 512; i++) begin slaveMem[i] = '0; refMem[i] = '0; end

    vecs[0] = '{9'h000, 4'hF, 32'hDEADDEAD, 0, 0, 0, 32'h0000_0000};
    vecs[1] = '{9'h000, 4'h0, 32'h1111_1111, 0, 0, 0, 32'hDEADDEAD};
    vecs[2] = '{9'h103, 4'hC, 32'hDEADBEEF, 3, 0, 0, 32'h0000_0000};
    vecs[3] = '{9'h103, 4'h0, 32'h0, 0, 2, 0, 32'hDEAD_0000};
    vecs[4] = '{9'h003, 4'h0, 32'h0, 0, 0, 0, 32'h0000_0000};
    vecs[5] = '{9'h0FF, 4'h3, 32'h1234_5678, 1, 1, 1, 32'h0000_0000};
    vecs[6] = '{9'h0FF, 4'h0, 32'h0, 0, 0, 0, 32'h0000_5678};
    vecs[7] = '{9'h010, 4'hF, 32'hFEEDBEEF, 0, 0, 0, 32'h0000_0000};
    vecs[8] = '{9'h010, 4'h0, 32'h0, 0, 0, 5, 32'hFEEDBEEF};

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_we = '0; cmd_data = '0;
    rsp_ready = 1'b0; wb_ack_i = 1'b0; wb_stall_i = 1'b0; wb_data_i = '0;
    #2;
    chk1("rst_stb", wb_stb_o, 1'b0);
    chk("rst_addr", 32'(wb_addr_o), 32'h0);
    chk("rst_we", 32'(wb_we_o), 32'h0);
    chk("rst_wdata", wb_data_o, 32'h0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    #6 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      void'(modelTxn(vecs[v].addr, vecs[v].we, vecs[v].data));
      doTxn(vecs[v].addr, vecs[v].we, vecs[v].data, vecs[v].nStall, vecs[v].ackDly,
            vecs[v].rspWait, vecs[v].expRsp);
    end

    // Stray ack while idle must not create a response.
    for (int i = 0; i < 2; i++) begin
      wb_ack_i = 1'b1; wb_data_i = 32'hBAD0_0000 + i;
      @(posedge clk); #1;
      chk1("stray_rsp_valid", rsp_valid, 1'b0);
      chk1("stray_cmd_ready", cmd_ready, 1'b1);
    end
    wb_ack_i = 1'b0;

    // Asynchronous reset in the middle of a stalled request.
    cmd_valid = 1'b1; cmd_addr = 9'h042; cmd_we = 4'hF; cmd_data = 32'hCAFE_F00D; wb_stall_i = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk1("arst_pre_stb", wb_stb_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("arst_stb", wb_stb_o, 1'b0);
    chk("arst_addr", 32'(wb_addr_o), 32'h0);
    chk1("arst_cmd_ready", cmd_ready, 1'b1);
    #1 rst = 1'b0;
    wb_stall_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wb_ack_i = 1'b1;
      @(posedge clk); #1;
      chk1("arst_late_ack_rsp", rsp_valid, 1'b0);
      chk1("arst_late_ack_stb", wb_stb_o, 1'b0);
    end
    wb_ack_i = 1'b0;
    ex = modelTxn(9'h042, 4'h0, 32'h0);
    doTxn(9'h042, 4'h0, 32'h0, 0, 0, 0, ex);

`ifdef WB_INIT_TIMEOUT_EN
    for (int pass = 0; pass < 2; pass++) begin
      cmd_valid = 1'b1; cmd_addr = 9'h005; cmd_we = 4'h0; cmd_data = '0; wb_stall_i = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while (!rsp_valid && n < 40) begin
        wb_ack_i  = (pass == 1 && n == 15);
        wb_data_i = 32'h0BAD_F00D;
        @(posedge clk); #1;
        n++;
      end
      wb_ack_i = 1'b0;
      chk("to_cycles", 32'(n), 32'd16);
      chk1("to_err", rsp_err, (pass == 0));
      chk("to_data", rsp_data, (pass == 0) ? 32'h0 : 32'h0BAD_F00D);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk1("to_done", rsp_valid, 1'b0);
    end
`endif

    for (int t = 0; t < 40; t++) begin
      ra = {1'($urandom), 8'($urandom_range(0, 7))};
      rw = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      rd = $urandom;
      ex = modelTxn(ra, rw, rd);
      doTxn(ra, rw, rd, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3), ex);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Single-outstanding Wishbone initiator that drives one port (A or B) of the dual-port `wishbone` RAM block.
- Converts a simple valid/ready command interface from a local controller into stb/addr/we/data bus cycles.
- Honours `stall` and waits for `ack`, then returns captured bus read data on a valid/ready response interface.
- Sits between a test sequencer or CPU-side logic and one slave port.

Parameters:
- A_WIDTH, 8, address MSB index; bus address is A_WIDTH+1 bits wide, and bit A_WIDTH selects the RAM bank.
- TIMEOUT, 16, maximum cycles to wait for ack before an error response; valid range 2..255. Used only with WB_INIT_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted this cycle when cmd_valid=1.
- cmd_addr  input  A_WIDTH+1  target word address.
- cmd_we  input  4  byte write enables; 0 = read.
- cmd_data  input  32  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed this cycle when rsp_valid=1.
- rsp_data  output  32  wb_data_i captured on ack.
- rsp_err  output  1  1 = transaction timed out.
- wb_stb_o  output  1  request strobe.
- wb_addr_o  output  A_WIDTH+1  bus address.
- wb_we_o  output  4  bus byte enables.
- wb_data_o  output  32  bus write data.
- wb_ack_i  input  1  slave acknowledge.
- wb_stall_i  input  1  slave stall; request not taken this cycle.
- wb_data_i  input  32  slave read data.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. On rst assertion all of the following are 0 immediately, without waiting for a clock edge: wb_stb_o, wb_addr_o, wb_we_o, wb_data_o, rsp_valid, rsp_data, rsp_err, and the timeout counter. State goes to IDLE.
- Reset mid-transaction: the request is abandoned, no response is produced, and a later stray ack is ignored because it arrives in IDLE.
- FSM states: IDLE, REQ, WAIT_ACK, RESP.
- IDLE:
  - cmd_ready=1 (combinational, state==IDLE).
  - On cmd_valid: register addr/we/data onto the wb_* outputs, set wb_stb_o=1, go to REQ.
- REQ:
  - wb_stb_o=1. wb_addr_o, wb_we_o and wb_data_o are held stable.
  - Edge with wb_stall_i=1: remain in REQ, unbounded.
  - Edge with wb_stall_i=0: request taken. wb_stb_o goes 0 next cycle; go to WAIT_ACK.
  - wb_ack_i is ignored in REQ.
- WAIT_ACK:
  - wb_stb_o=0; wb_addr_o, wb_we_o and wb_data_o keep their last values.
  - On wb_ack_i=1: rsp_data<=wb_data_i (for reads and writes alike), rsp_err<=0, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid=1 and rsp_data is stable until rsp_ready=1.
  - On the handshake edge: rsp_valid<=0, go to IDLE.
  - No new command is accepted in the same cycle (cmd_ready=0 in RESP).
- Minimum latency: cmd handshake at edge N, wb_stb_o high in cycle N+1, ack sampled from cycle N+2, rsp_valid high the cycle after ack. Best case is cmd to rsp_valid in 3 cycles.
- Throughput: at most one outstanding transaction. wb_stb_o is never high in two consecutive accepted cycles.
- wb_ack_i seen in IDLE or RESP: ignored, with no state change.

Optional Feature:
- Macro: WB_INIT_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle without ack.
  - When it reaches TIMEOUT-1 without ack: rsp_data<=0, rsp_err<=1, go to RESP.
  - An ack in the same cycle as expiry takes priority and gives a normal response.
- Undefined:
  - No counter. WAIT_ACK waits indefinitely and rsp_err is tied to 0.

Test Plan:
1. Write then read: cmd addr=0x000, we=0xF, data=0xDEADDEAD, slave no stall and ack 1 cycle after accept -> one stb pulse with addr/we/data as given. Read cmd addr=0x000, we=0 -> rsp_data=0xDEADDEAD, rsp_err=0, rsp_valid 3 cycles after cmd handshake.
2. Stall: hold wb_stall_i=1 for 3 cycles on cmd addr=0x103, we=0xC, data=0xDEADBEEF -> wb_stb_o high for 4 cycles with addr/we/data unchanged, cmd_ready=0 throughout, exactly one transaction completes.
3. Response backpressure: rsp_ready=0 for 5 cycles after ack with wb_data_i=0xFEEDBEEF -> rsp_valid held, rsp_data stays 0xFEEDBEEF, cmd_ready=0. rsp_ready=1 -> IDLE next cycle.
4. Timeout (macro defined, TIMEOUT=16): slave never acks -> rsp_valid with rsp_err=1 and rsp_data=0 exactly 16 cycles after stb acceptance. Repeat with ack on cycle 16 -> rsp_err=0.
5. Async reset mid-REQ, with wb_stall_i=1 and stb high: pulse rst between edges -> wb_stb_o drops before the next edge. A later ack produces no rsp_valid, and the next command completes normally.
6. Stray ack in IDLE for 2 cycles -> rsp_valid stays 0 and cmd_ready stays 1.
